// File: rtl/mmem_pkg.sv
// mmem_pkg: shared constants and types for the M-memory write queue slice.
//   MMEM_AW / MMEM_DW / MMEM_WORDS : geometry of the 32x32 M-memory RAM.
//   mmem_state_e                   : front-end FSM states (zero-fill, normal run).
//   wq_entry_t                     : one queued write-back (address + data).
package mmem_pkg;

  localparam int MMEM_AW    = 5;
  localparam int MMEM_DW    = 32;
  localparam int MMEM_WORDS = 32;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } mmem_state_e;

  typedef struct packed {
    logic [MMEM_AW-1:0] addr;
    logic [MMEM_DW-1:0] data;
  } wq_entry_t;

endpackage

// File: rtl/mmem_write_queue_if.sv
// mmem_write_queue_if: client and RAM A-port bundle for mmem_write_queue.
//   Client side : wr_valid/wr_ready/wr_addr/wr_data (write-back),
//                 rd_req/rd_addr -> rd_valid/rd_data (read),
//                 init_busy, fifo_count (status).
//   RAM side    : ram_address/ram_data/ram_wren/ram_rden -> RAM port A,
//                 ram_q <- RAM q_a (registered, one cycle latency).
//   slave  modport : the write-queue front end.
//   master modport : the environment (client plus RAM).
interface mmem_write_queue_if
  import mmem_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = MMEM_AW,
  parameter int DW    = MMEM_DW
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          init_busy;
  logic [CW-1:0] fifo_count;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_data;
  logic          ram_wren;
  logic          ram_rden;
  logic [DW-1:0] ram_q;

  modport slave (
    input  wr_valid, wr_addr, wr_data, rd_req, rd_addr, ram_q,
    output wr_ready, rd_data, rd_valid, init_busy, fifo_count,
           ram_address, ram_data, ram_wren, ram_rden
  );

  modport master (
    output wr_valid, wr_addr, wr_data, rd_req, rd_addr, ram_q,
    input  wr_ready, rd_data, rd_valid, init_busy, fifo_count,
           ram_address, ram_data, ram_wren, ram_rden
  );

endinterface

// File: rtl/mmem_wq_fifo.sv
// mmem_wq_fifo: write-back FIFO with a parallel address lookup.
//   clk_a, reset    : clock and synchronous active-high reset (flushes).
//   i_push          : enqueue i_push_entry (ignored when full).
//   i_pop           : drop the head entry (ignored when empty).
//   i_match_addr    : address compared against every occupied entry.
//   o_head          : oldest entry.
//   o_count         : occupied entries, 0..DEPTH.
//   o_hit           : some occupied entry holds i_match_addr.
//   o_hit_data      : data of the youngest such entry.
module mmem_wq_fifo
  import mmem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk_a,
  input  logic                     reset,
  input  logic                     i_push,
  input  wq_entry_t                i_push_entry,
  input  logic                     i_pop,
  input  logic [MMEM_AW-1:0]       i_match_addr,
  output wq_entry_t                o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_hit,
  output logic [MMEM_DW-1:0]       o_hit_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  wq_entry_t        r_mem [DEPTH];
  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [CW-1:0]    r_count;

  logic             w_push;
  logic             w_pop;
  logic [PW-1:0]    w_slot [DEPTH];
  logic [DEPTH-1:0] w_match;
  logic [PW-1:0]    w_hit_idx;

  assign w_push = i_push && (r_count != FULL_CNT);
  assign w_pop  = i_pop  && (r_count != {CW{1'b0}});

  // Storage is not reset: an entry only matters while the count covers it.
  always_ff @(posedge clk_a) begin
    if (w_push) begin
      r_mem[r_tail] <= i_push_entry;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two; fullness comes from the count.
  always_ff @(posedge clk_a) begin
    if (reset) begin
      r_head  <= {PW{1'b0}};
      r_tail  <= {PW{1'b0}};
      r_count <= {CW{1'b0}};
    end else begin
      if (w_push) begin
        r_tail <= r_tail + 1'b1;
      end
      if (w_pop) begin
        r_head <= r_head + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Slot k is the k-th oldest entry; it is occupied when k < count.
  for (genvar k = 0; k < DEPTH; k++) begin : g_slot
    assign w_slot[k]  = r_head + PW'(k);
    assign w_match[k] = (CW'(k) < r_count) && (r_mem[w_slot[k]].addr == i_match_addr);
  end

  // Scan oldest to youngest so the last (youngest) match wins.
  always_comb begin
    w_hit_idx = {PW{1'b0}};
    for (int k = 0; k < DEPTH; k++) begin
      if (w_match[k]) begin
        w_hit_idx = w_slot[k];
      end else begin
        w_hit_idx = w_hit_idx;
      end
    end
  end

  assign o_hit      = |w_match;
  assign o_hit_data = r_mem[w_hit_idx].data;
  assign o_head     = r_mem[r_head];
  assign o_count    = r_count;

endmodule

// File: rtl/mmem_write_queue.sv
// mmem_write_queue: front end for port A of the 32x32 M-memory RAM.
//   clk_a, reset : clock (shared with RAM port A), synchronous active-high reset.
//   bus (slave)  : client write/read requests, status, and the RAM A port.
// After reset the RAM is zero-filled (INIT_ON_RESET=1), then writes are
// queued and drained only in cycles without a read, so reads always own the
// shared address bus. Reads that hit a queued write return the youngest
// queued data instead of the stale RAM word.
module mmem_write_queue
  import mmem_pkg::*;
#(
  parameter int DEPTH         = 4,
  parameter int AW            = MMEM_AW,
  parameter int DW            = MMEM_DW,
  parameter int INIT_ON_RESET = 1
) (
  input  logic               clk_a,
  input  logic               reset,
  mmem_write_queue_if.slave  bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [AW-1:0] INIT_LAST = AW'(MMEM_WORDS - 1);

  mmem_state_e   r_state;
  mmem_state_e   w_state_nxt;
  logic [AW-1:0] r_init_cnt;
  logic          r_rd_valid;
  logic          r_fwd_hit;
  logic [DW-1:0] r_fwd_data;
  logic [DW-1:0] r_rd_hold;

  logic          w_init_busy;
  logic          w_wr_ready;
  logic          w_push;
  logic          w_pop;
  logic          w_rd_accept;
  logic [AW-1:0] w_ram_address;
  logic [DW-1:0] w_ram_data;
  logic          w_ram_wren;
  logic          w_ram_rden;
  logic [DW-1:0] w_rd_data;

  wq_entry_t     w_push_entry;
  wq_entry_t     w_head;
  logic [CW-1:0] w_count;
  logic          w_hit;
  logic [DW-1:0] w_hit_data;

  assign w_push_entry = {bus.wr_addr, bus.wr_data};

  mmem_wq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_a        (clk_a),
    .reset        (reset),
    .i_push       (w_push),
    .i_push_entry (w_push_entry),
    .i_pop        (w_pop),
    .i_match_addr (bus.rd_addr),
    .o_head       (w_head),
    .o_count      (w_count),
    .o_hit        (w_hit),
    .o_hit_data   (w_hit_data)
  );

  // State register.
  always_ff @(posedge clk_a) begin
    if (reset) begin
      r_state <= (INIT_ON_RESET != 0) ? ST_INIT : ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: leave INIT once the last word has been written.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INIT: begin
        if (r_init_cnt == INIT_LAST) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_INIT;
        end
      end
      ST_RUN:  w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_INIT;
    endcase
  end

  // Zero-fill address counter; restarts from 0 on every reset.
  always_ff @(posedge clk_a) begin
    if (reset) begin
      r_init_cnt <= {AW{1'b0}};
    end else if (r_state == ST_INIT) begin
      r_init_cnt <= r_init_cnt + 1'b1;
    end else begin
      r_init_cnt <= {AW{1'b0}};
    end
  end

  // Outputs and port arbitration: a read takes the port, otherwise drain the head.
  always_comb begin
    w_init_busy   = 1'b0;
    w_wr_ready    = 1'b0;
    w_push        = 1'b0;
    w_pop         = 1'b0;
    w_rd_accept   = 1'b0;
    w_ram_address = {AW{1'b0}};
    w_ram_data    = {DW{1'b0}};
    w_ram_wren    = 1'b0;
    w_ram_rden    = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_init_busy   = 1'b1;
        w_ram_address = r_init_cnt;
        w_ram_wren    = 1'b1;
      end
      ST_RUN: begin
        w_wr_ready = (w_count != FULL_CNT);
        w_push     = bus.wr_valid && w_wr_ready;
        if (bus.rd_req) begin
          w_ram_address = bus.rd_addr;
          w_ram_rden    = 1'b1;
          w_rd_accept   = 1'b1;
        end else if (w_count != {CW{1'b0}}) begin
          w_ram_address = w_head.addr;
          w_ram_data    = w_head.data;
          w_ram_wren    = 1'b1;
          w_pop         = 1'b1;
        end else begin
          w_ram_wren    = 1'b0;
          w_ram_rden    = 1'b0;
        end
      end
      default: begin
        w_init_busy = 1'b0;
      end
    endcase
  end

  // Read pipeline: capture forwarding decision alongside the RAM read.
  // The lookup sees only entries queued before this cycle, so a same-cycle
  // write does not affect the read.
  always_ff @(posedge clk_a) begin
    if (reset) begin
      r_rd_valid <= 1'b0;
      r_fwd_hit  <= 1'b0;
      r_fwd_data <= {DW{1'b0}};
    end else begin
      r_rd_valid <= w_rd_accept;
      if (w_rd_accept) begin
        r_fwd_hit  <= w_hit;
        r_fwd_data <= w_hit_data;
      end
    end
  end

  assign w_rd_data = r_fwd_hit ? r_fwd_data : bus.ram_q;

  // Hold the last returned word so rd_data is stable between reads.
  always_ff @(posedge clk_a) begin
    if (reset) begin
      r_rd_hold <= {DW{1'b0}};
    end else if (r_rd_valid) begin
      r_rd_hold <= w_rd_data;
    end
  end

  assign bus.rd_data     = r_rd_valid ? w_rd_data : r_rd_hold;
  assign bus.rd_valid    = r_rd_valid;
  assign bus.init_busy   = w_init_busy;
  assign bus.wr_ready    = w_wr_ready;
  assign bus.fifo_count  = w_count;
  assign bus.ram_address = w_ram_address;
  assign bus.ram_data    = w_ram_data;
  assign bus.ram_wren    = w_ram_wren;
  assign bus.ram_rden    = w_ram_rden;

endmodule

// File: tb/tb_mmem_write_queue.sv
// tb_mmem_write_queue: self-checking bench for mmem_write_queue.
// A behavioural RAM sits on the A port. A scoreboard mirrors the memory as
// seen by a client (updated at each accepted write), queues the expected read
// data and the expected RAM write order, and checks them as the DUT responds.
module tb_mmem_write_queue;
  import mmem_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;

  logic clk_a = 1'b0;
  logic reset;

  always #5 clk_a = ~clk_a;

  mmem_write_queue_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus ();

  mmem_write_queue #(
    .DEPTH         (DEPTH),
    .AW            (AW),
    .DW            (DW),
    .INIT_ON_RESET (1)
  ) dut (
    .clk_a (clk_a),
    .reset (reset),
    .bus   (bus)
  );

  // Behavioural RAM port A with registered read data.
  logic [DW-1:0] ram [32];
  logic [DW-1:0] ram_q_r;
  always @(posedge clk_a) begin
    if (bus.ram_wren) ram[bus.ram_address] <= bus.ram_data;
    if (bus.ram_rden) ram_q_r <= ram[bus.ram_address];
  end
  assign bus.ram_q = ram_q_r;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard state.
  logic [DW-1:0]    rd_q [$];
  logic [AW+DW-1:0] wr_q [$];
  logic [DW-1:0]    ref_mem [32];
  logic             exp_rv = 1'b0;

  initial begin
    forever begin
      @(negedge clk_a);
      if (reset === 1'b1) begin
        rd_q.delete();
        wr_q.delete();
        exp_rv = 1'b0;
        for (int i = 0; i < 32; i++) ref_mem[i] = '0;
      end else begin
        if (bus.rd_valid === 1'b1 || exp_rv) begin
          check("rd_valid", bus.rd_valid, exp_rv);
          if (exp_rv && rd_q.size() > 0) check("rd_data", bus.rd_data, rd_q.pop_front());
        end
        if (bus.ram_wren === 1'b1 && bus.init_busy === 1'b0) begin
          if (wr_q.size() == 0) check("wr_unexpected", 64'd1, 64'd0);
          else check("wr_order", {bus.ram_address, bus.ram_data}, wr_q.pop_front());
        end
        exp_rv = (bus.rd_req === 1'b1) && (bus.init_busy === 1'b0);
        if (exp_rv) rd_q.push_back(ref_mem[bus.rd_addr]);
        if (bus.wr_valid === 1'b1 && bus.wr_ready === 1'b1) begin
          wr_q.push_back({bus.wr_addr, bus.wr_data});
          ref_mem[bus.wr_addr] = bus.wr_data;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_a);
    #1;
  endtask

  // Walk the zero-fill, checking address/controls each cycle and its length.
  task automatic init_phase();
    int n;
    n = 0;
    #1;
    while (bus.init_busy === 1'b1 && n < 40) begin
      check("init_addr", bus.ram_address, n);
      check("init_ctl", {bus.ram_wren, bus.ram_rden, bus.wr_ready, |bus.ram_data}, 4'b1000);
      n++;
      @(posedge clk_a);
      #2;
    end
    check("init_len", n, 32);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    reset        = 1'b1;
    bus.wr_valid = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.rd_req   = 1'b0;
    bus.rd_addr  = '0;
    tick();
    tick();
    #1;
    check("rst_count", bus.fifo_count, 0);
    check("rst_rd", {bus.rd_valid, bus.rd_data}, 33'h0);
    check("rst_busy_ready", {bus.init_busy, bus.wr_ready}, 2'b10);

    // Zero-fill, then reset at fill cycle 10 with reads pending (ignored).
    reset = 1'b0;
    init_phase();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.rd_req  = 1'b1;
    bus.rd_addr = 5'd3;
    for (int i = 0; i < 10; i++) tick();
    #1;
    check("init_mid_addr", bus.ram_address, 10);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    init_phase();
    bus.rd_req = 1'b0;
    tick();

    // Single write with no reads, then read it back through the RAM.
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 5'd5;
    bus.wr_data  = 32'h1234_5678;
    #1;
    check("wr_ready_idle", bus.wr_ready, 1);
    tick();
    bus.wr_valid = 1'b0;
    #1;
    check("w5_count", bus.fifo_count, 1);
    check("w5_drain", {bus.ram_wren, bus.ram_address, bus.ram_data}, {1'b1, 5'd5, 32'h1234_5678});
    tick();
    #1;
    check("w5_empty", bus.fifo_count, 0);
    bus.rd_req  = 1'b1;
    bus.rd_addr = 5'd5;
    tick();
    bus.rd_req = 1'b0;
    #1;
    check("r5_valid", bus.rd_valid, 1);
    check("r5_data", bus.rd_data, 32'h1234_5678);
    tick();
    #1;
    check("r5_hold", {bus.rd_valid, bus.rd_data}, {1'b0, 32'h1234_5678});

    // Forwarding: two writes to 7 while reads of 7 hold the port.
    bus.rd_req   = 1'b1;
    bus.rd_addr  = 5'd7;
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 5'd7;
    bus.wr_data  = 32'h0000_000A;
    tick();
    bus.wr_data  = 32'h0000_000B;
    tick();
    bus.wr_valid = 1'b0;
    tick();
    #1;
    check("fwd_data", bus.rd_data, 32'h0000_000B);
    check("fwd_count", bus.fifo_count, 2);
    bus.rd_req = 1'b0;
    tick();
    tick();
    check("fwd_ram7", ram[7], 32'h0000_000B);
    check("fwd_empty", bus.fifo_count, 0);

    // Full: five writes while reads starve the drain.
    bus.rd_req  = 1'b1;
    bus.rd_addr = 5'd5;
    for (int i = 0; i < 4; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_addr  = 5'(10 + i);
      bus.wr_data  = 32'hC0DE_0000 + 32'(i);
      #1;
      check("full_acc", bus.wr_ready, 1);
      tick();
    end
    bus.wr_addr = 5'd14;
    bus.wr_data = 32'hC0DE_0004;
    #1;
    check("full_ready", bus.wr_ready, 0);
    check("full_count", bus.fifo_count, 4);
    tick();
    #1;
    check("full_stall", {bus.wr_ready, bus.fifo_count}, {1'b0, 3'd4});
    bus.rd_req = 1'b0;
    w = 0;
    #1;
    while (bus.wr_ready !== 1'b1 && w < 10) begin
      tick();
      w++;
    end
    check("full_wait", w, 1);
    tick();
    bus.wr_valid = 1'b0;
    w = 0;
    while (bus.fifo_count !== 3'd0 && w < 20) begin
      tick();
      w++;
    end
    check("drain_done", bus.fifo_count, 0);
    tick();
    for (int i = 0; i < 32; i++) check("ram_word", ram[i], ref_mem[i]);

    // Reset during RUN with three queued writes.
    bus.rd_req  = 1'b1;
    bus.rd_addr = 5'd5;
    for (int i = 0; i < 3; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_addr  = 5'(20 + i);
      bus.wr_data  = 32'hDEAD_0000 + 32'(i);
      tick();
    end
    bus.wr_valid = 1'b0;
    tick();
    #1;
    check("q3_count", bus.fifo_count, 3);
    check("q3_rdata", bus.rd_data, 32'h1234_5678);
    reset = 1'b1;
    tick();
    #1;
    check("rr_count", bus.fifo_count, 0);
    check("rr_rd", {bus.rd_valid, bus.rd_data}, 33'h0);
    bus.rd_req = 1'b0;
    reset = 1'b0;
    init_phase();
    for (int i = 0; i < 4; i++) tick();
    check("rr_count_run", bus.fifo_count, 0);
    for (int i = 20; i < 23; i++) check("rr_ram", ram[i], 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
